data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Data-memory responder for the RISC-V core's load/store port: the core initiates with memRd/memWrt, address (ALU result) and store data (readData2), and this block answers.
- Holds a word-organised RAM.
- Performs byte/half/word stores with byte lanes; performs sign/zero-extended loads.
- Inserts a programmable number of wait states.
- Signals completion with a one-cycle ready pulse and flags illegal accesses.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2^ADDR_WIDTH 32-bit words (byte range 0 .. 4*2^ADDR_WIDTH-1)
WAIT_STATES, 1, extra cycles between request acceptance and array access (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_  input  1  reset; one clock; reset is synchronous and active-high
memRd  input  1  load request from core controller
memWrt  input  1  store request from core controller
addr  input  32  byte address (ALU result Y)
wrData  input  32  store data (readData2), right-aligned
funct3  input  3  instruction[14:12], selects access size/extension
rdData  output  32  load result, extended to 32 bits, feeds memToReg mux
ready  output  1  one-cycle completion pulse
err  output  1  illegal access, valid only with ready

Behaviour:
- Reset (rst_=1 at an edge): state IDLE, rdData=0, ready=0, err=0, wait counter=0. RAM contents are not cleared.
- Reset arriving in WAIT or ACCESS aborts the transaction: no RAM write occurs, and no ready is issued.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE: on an edge with memRd|memWrt=1, latch addr, wrData, funct3 and the rd/wr kind.
  - Go to WAIT if WAIT_STATES>0, else ACCESS.
  - Load counter with WAIT_STATES-1.
- WAIT: decrement the counter each edge; go to ACCESS on the edge where counter==0.
- ACCESS: perform or reject the access (single edge), then go to DONE.
  - ready=1 and rdData/err are registered for exactly the one DONE entry cycle.
- DONE: ready=0 after the first cycle. Stay until memRd=0 and memWrt=0 at an edge, then IDLE.
  - A held request is never served twice. The core must drop the request before a new one is accepted.
- Latency: request sampled at edge N → ready high in the cycle after edge N+WAIT_STATES+1.
- Inputs are ignored outside IDLE; the latched copies are used.
- rdData holds its value until the next completed load. Stores and errors drive rdData=0 with ready.
- Word index = addr[ADDR_WIDTH+1:2]; lane = addr[1:0].
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the half at addr[1].
  - 101 LHU: zero-extend the half at addr[1].
  - 010 LW: full word.
- Stores:
  - 000 SB: write wrData[7:0] to lane addr[1:0] only.
  - 001 SH: write wrData[15:0] to half addr[1].
  - 010 SW: write all 4 lanes.
  - Unselected bytes are unchanged.
- err=1, no RAM write, rdData=0 when any of the following holds:
  - memRd and memWrt both 1 at acceptance;
  - funct3 is 011/110/111 for a load, or >010 for a store;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:ADDR_WIDTH+2]≠0 (out of range).
- Simultaneous events: a request arriving in the same cycle as ready is not accepted; acceptance requires passing through IDLE. Reset has priority over everything.

Test Plan:
1. Reset, then SW addr=0x10 wrData=0xDEADBEEF, WAIT_STATES=1 → ready 3rd cycle after sampling edge, err=0. Then LW addr=0x10 → rdData=0xDEADBEEF.
2. After test 1: SB addr=0x11 wrData=0x000000A5, then LW 0x10 → 0xDEADA5EF. LB 0x11 → 0xFFFFFFA5; LBU 0x11 → 0x000000A5; LH 0x12 → 0xFFFFDEAD; LHU 0x12 → 0x0000DEAD.
3. LW addr=0x12 and SH addr=0x13 → ready with err=1, rdData=0, word 0x10 unchanged. LW addr=0x00001000 (ADDR_WIDTH=10) → err=1. memRd=memWrt=1 → err=1, no write.
4. Hold memRd=1 for 10 cycles after ready → exactly one ready pulse, FSM stays DONE. Drop for one cycle, then reassert → second pulse after expected latency.
5. SW 0x20=0x12345678 with rst_ asserted during WAIT → no ready. After reset, LW 0x20 returns prior contents (not 0x12345678).
6. WAIT_STATES=0 build: request sampled at edge N → ready in cycle after edge N+1. Back-to-back requests with one idle cycle → correct data each time.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port: word-organised RAM with
// byte-lane stores, extended loads, programmable wait states and a one-cycle ready pulse.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        memRd,
  input  logic        memWrt,
  input  logic [31:0] addr,
  input  logic [31:0] wrData,
  input  logic [2:0]  funct3,
  output logic [31:0] rdData,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Handshake: a request is accepted only in IDLE; ready pulses for one cycle on
  // entry to DONE, and the core must drop memRd/memWrt before the next request.
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_rd_q, is_rd_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           mem_word;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [31:0]           load_val;
  logic [3:0]            be;
  logic [31:0]           wd_lanes;
  logic                  acc_err;
  logic                  mem_we;

  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  assign lane     = addr_q[1:0];
  assign mem_word = mem[word_idx];

  always_comb begin
    byte_v = 8'd0;
    case (lane)
      2'd0: byte_v = mem_word[7:0];
      2'd1: byte_v = mem_word[15:8];
      2'd2: byte_v = mem_word[23:16];
      2'd3: byte_v = mem_word[31:24];
      default: byte_v = 8'd0;
    endcase
    half_v = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    load_val = 32'd0;
    case (funct3_q)
      3'b000: load_val = {{24{byte_v[7]}}, byte_v};
      3'b100: load_val = {24'd0, byte_v};
      3'b001: load_val = {{16{half_v[15]}}, half_v};
      3'b101: load_val = {16'd0, half_v};
      3'b010: load_val = mem_word;
      default: load_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be       = 4'b0000;
    wd_lanes = 32'd0;
    case (funct3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << lane;
        wd_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be       = 4'b1111;
        wd_lanes = wdata_q;
      end
      default: begin
        be       = 4'b0000;
        wd_lanes = 32'd0;
      end
    endcase
  end

  always_comb begin
    acc_err = 1'b0;
    if (is_rd_q && is_wr_q) acc_err = 1'b1;
    if (is_rd_q && (funct3_q == 3'b011 || funct3_q[2:1] == 2'b11)) acc_err = 1'b1;
    if (is_wr_q && (funct3_q > 3'b010)) acc_err = 1'b1;
    if (funct3_q[1:0] == 2'b01 && addr_q[0]) acc_err = 1'b1;
    if (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) acc_err = 1'b1;
    if ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0) acc_err = 1'b1;
  end

  // A reset landing on the ACCESS edge must suppress the write.
  assign mem_we = (state_q == S_ACCESS) && is_wr_q && !acc_err && !rst_;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    is_rd_d   = is_rd_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memRd || memWrt) begin
          addr_d   = addr;
          wdata_d  = wrData;
          funct3_d = funct3;
          is_rd_d  = memRd;
          is_wr_d  = memWrt;
          cnt_d    = WS_INIT;
          state_d  = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d   = S_DONE;
        ready_d   = 1'b1;
        err_d     = acc_err;
        rd_data_d = (is_rd_q && !acc_err) ? load_val : 32'd0;
      end
      S_DONE: begin
        if (!memRd && !memWrt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      funct3_q  <= 3'd0;
      is_rd_q   <= 1'b0;
      is_wr_q   <= 1'b0;
      rd_data_q <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      is_rd_q   <= is_rd_d;
      is_wr_q   <= is_wr_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && be[b]) mem[word_idx][8*b +: 8] <= wd_lanes[8*b +: 8];
    end
  end

  assign rdData = rd_data_q;
  assign ready  = ready_q;
  assign err    = err_q;

endmodule
